// File: rtl/cache_valid_array_pkg.sv
// cache_valid_array_pkg: clear-FSM states and default geometry shared with the tag array
package cache_pkg;
  typedef enum logic {CV_IDLE, CV_SWEEP} cv_state_e;
  localparam int CV_SETS = 2048;
  localparam int CV_WAYS = 2;
endpackage

// File: rtl/cache_valid_array_if.sv
// cache_valid_array_if: lookup/update/flush bus between the cache controller and the valid array
interface cache_valid_array_if #(
  parameter int SETS = cache_pkg::CV_SETS,
  parameter int WAYS = cache_pkg::CV_WAYS
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  logic flush_req;
  logic busy;
  logic rd_en;
  logic [SET_W-1:0] rd_set;
  logic [WAYS-1:0] rd_valid;
  logic [WAYS-1:0] rd_dirty;
  logic wr_en;
  logic [SET_W-1:0] wr_set;
  logic [WAY_W-1:0] wr_way;
  logic wr_valid;
  logic wr_dirty;
  modport master (
    output flush_req, rd_en, rd_set, wr_en, wr_set, wr_way, wr_valid, wr_dirty,
    input busy, rd_valid, rd_dirty
  );
  modport slave (
    input flush_req, rd_en, rd_set, wr_en, wr_set, wr_way, wr_valid, wr_dirty,
    output busy, rd_valid, rd_dirty
  );
endinterface

// File: rtl/cache_valid_array_sweep_ctrl.sv
// cv_sweep_ctrl: clear-sweep FSM walking clr_idx over every set once per rst/flush
module cv_sweep_ctrl import cache_pkg::*; #(
  parameter int SETS = CV_SETS,
  localparam int SET_W = $clog2(SETS)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_req,
  output logic busy,
  output logic [SET_W-1:0] clr_idx
);
  cv_state_e state, state_n;
  logic [SET_W-1:0] idx_n;
  logic last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CV_SWEEP;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      clr_idx <= idx_n;
    end
  end
  // flush during a sweep is ignored; the index wraps to 0 exactly on the last set
  always_comb begin
    last = clr_idx == SET_W'(SETS - 1);
    state_n = state == CV_IDLE ? (flush_req ? CV_SWEEP : CV_IDLE) : (last ? CV_IDLE : CV_SWEEP);
    idx_n = state == CV_SWEEP ? clr_idx + 1'b1 : '0;
    busy = state == CV_SWEEP;
  end
endmodule

// File: rtl/cache_valid_array.sv
// cache_valid_array: per-(set,way) valid bits with registered lookup and sequential clear sweep.
// Define CACHE_DIRTY_EN to add a parallel dirty array sharing indexing and sweep.
module cache_valid_array import cache_pkg::*; #(
  parameter int SETS = CV_SETS,
  parameter int WAYS = CV_WAYS
) (
  input logic clk,
  input logic rst,
  cache_valid_array_if.slave bus
);
  localparam int SET_W = $clog2(SETS);
  logic busy;
  logic we;
  logic [SET_W-1:0] clr_idx;
  logic [WAYS-1:0] valid_mem [SETS];
  cv_sweep_ctrl #(.SETS(SETS)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .flush_req(bus.flush_req),
    .busy(busy),
    .clr_idx(clr_idx)
  );
  assign bus.busy = busy;
  // a flush in the same cycle wins over the write
  assign we = bus.wr_en && !busy && !bus.flush_req && 32'(bus.wr_way) < WAYS;
  always_ff @(posedge clk) begin
    if (busy) valid_mem[clr_idx] <= '0;
    else if (we) valid_mem[bus.wr_set][bus.wr_way] <= bus.wr_valid;
    if (rst) bus.rd_valid <= '0;
    else if (bus.rd_en) bus.rd_valid <= busy ? '0 : valid_mem[bus.rd_set];
  end
`ifdef CACHE_DIRTY_EN
  logic [WAYS-1:0] dirty_mem [SETS];
  always_ff @(posedge clk) begin
    if (busy) dirty_mem[clr_idx] <= '0;
    else if (we) dirty_mem[bus.wr_set][bus.wr_way] <= bus.wr_valid & bus.wr_dirty;
    if (rst) bus.rd_dirty <= '0;
    else if (bus.rd_en) bus.rd_dirty <= busy ? '0 : dirty_mem[bus.rd_set];
  end
`else
  logic unused_dirty;
  assign unused_dirty = bus.wr_dirty;
  assign bus.rd_dirty = '0;
`endif
  a_wr_way: assert property (@(posedge clk) disable iff (rst) bus.wr_en |-> 32'(bus.wr_way) < WAYS);
endmodule

// File: tb/tb_cache_valid_array.sv
// tb_cache_valid_array: directed scoreboard bench for the valid array (SETS=16, WAYS=2)
module tb_cache_valid_array;
  localparam int SETS = 16;
  localparam int WAYS = 2;
`ifdef CACHE_DIRTY_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_pend = 1'b0;
  logic [2*WAYS-1:0] exp_q[$];
  logic [2*WAYS-1:0] e;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  cache_valid_array_if #(.SETS(SETS), .WAYS(WAYS)) bus();
  cache_valid_array #(.SETS(SETS), .WAYS(WAYS)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) rd_pend <= bus.rd_en;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: read response with empty scoreboard at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_valid", 32'(bus.rd_valid), 32'(e[WAYS-1:0]));
        chk("rd_dirty", 32'(bus.rd_dirty), 32'(e[2*WAYS-1:WAYS]));
      end
    end
  end
  task automatic op(input bit r, input int rs, input logic [1:0] ev, input logic [1:0] ed,
                    input bit w, input int ws, input int wy, input logic wv, input logic wd);
    bus.rd_en = r;
    bus.rd_set = 4'(rs);
    bus.wr_en = w;
    bus.wr_set = 4'(ws);
    bus.wr_way = 1'(wy);
    bus.wr_valid = wv;
    bus.wr_dirty = wd;
    if (r) exp_q.push_back({ed, ev});
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask
  task automatic rd(input int s, input logic [1:0] ev, input logic [1:0] ed = 2'b00);
    op(1'b1, s, ev, ed, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  task automatic wr(input int s, input int wy, input logic wv, input logic wd = 1'b0);
    op(1'b0, 0, 2'b00, 2'b00, 1'b1, s, wy, wv, wd);
  endtask
  task automatic busy_len(input string name, input int exp, input int reflush_at);
    int n = 0;
    while (bus.busy && n < 100) begin
      bus.flush_req = (n == reflush_at);
      @(negedge clk);
      n++;
    end
    bus.flush_req = 1'b0;
    chk(name, 32'(n), 32'(exp));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.flush_req = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_set = '0;
    bus.wr_en = 1'b0;
    bus.wr_set = '0;
    bus.wr_way = '0;
    bus.wr_valid = 1'b0;
    bus.wr_dirty = 1'b0;
    // 1: reset sweep
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_busy", 32'(bus.busy), 1);
    busy_len("reset_sweep_len", 16, -1);
    for (int s = 0; s < SETS; s++) rd(s, 2'b00);
    // 2: fill and lookup
    wr(5, 1, 1'b1);
    rd(5, 2'b10);
    rd(4, 2'b00);
    rd(6, 2'b00);
    // 3: same-cycle read/write returns old contents
    op(1'b1, 3, 2'b00, 2'b00, 1'b1, 3, 0, 1'b1, 1'b0);
    rd(3, 2'b01);
    // 4: flush with concurrent write, re-flush mid-sweep ignored
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) wr(s, w, 1'b1);
    rd(9, 2'b11);
    rd(2, 2'b11);
    bus.flush_req = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_set = 4'd2;
    bus.wr_way = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    bus.flush_req = 1'b0;
    bus.wr_en = 1'b0;
    busy_len("flush_sweep_len", 16, 8);
    for (int s = 0; s < SETS; s++) rd(s, 2'b00);
    // 5: reset mid-sweep restarts it; writes and reads while busy
    wr(1, 0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_rst2", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op(1'b1, 1, 2'b00, 2'b00, 1'b1, 12, 1, 1'b1, 1'b0);
    busy_len("rst_restart_len", 15, -1);
    rd(12, 2'b00);
    rd(1, 2'b00);
    // 6: dirty bits (constant 0 when the dirty array is not built)
    wr(7, 0, 1'b1, 1'b1);
    rd(7, 2'b01, DE ? 2'b01 : 2'b00);
    wr(7, 0, 1'b0, 1'b1);
    rd(7, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
